// File: rtl/mem_wb_pkg.sv
// Shared types for the posted-write buffer: FSM states, buffered write entry
// and the registered memory-side command.
package mem_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN_REQ,
    DRAIN_WAIT,
    READ_REQ,
    READ_WAIT
  } wb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wb_entry_t;

  localparam int WB_ENTRY_W = 68;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_cmd_t;

  function automatic mem_cmd_t drain_cmd(input wb_entry_t e);
    drain_cmd = '{req: 1'b1, we: 1'b1, addr: e.addr, wdata: e.wdata, be: e.be};
  endfunction

  // Line fills always fetch the whole word.
  function automatic mem_cmd_t read_cmd(input logic [31:0] addr);
    read_cmd = '{req: 1'b1, we: 1'b0, addr: addr, wdata: 32'h0, be: 4'hF};
  endfunction

endpackage

// File: rtl/mem_write_buffer_if.sv
// req/gnt/rvalid word bus; the requester uses the master modport, the
// responder the slave modport.
interface mem_write_buffer_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        req;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        gnt;
  logic        rvalid;
  logic        error;

  modport master (
    output addr, wdata, we, req, be,
    input  rdata, gnt, rvalid, error
  );

  modport slave (
    input  addr, wdata, we, req, be,
    output rdata, gnt, rvalid, error
  );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of buffered write entries with a combinational head view.
// The caller never pushes when full nor pops when empty.
module wb_fifo
  import mem_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_data,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WB_ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = wb_entry_t'(mem_q[rd_ptr_q]);
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer: cache writes are acked at once and drained to memory in
// order; reads wait until the buffer is empty, which keeps read-after-write order.
module mem_write_buffer
  import mem_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_write_buffer_if.slave  cache,
  mem_write_buffer_if.master mem,
  output logic               wr_err_o,
  output logic               empty_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_state_e   state_q, state_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic [31:0] cache_rdata_q, cache_rdata_d;
  logic        cache_rvalid_q, cache_rvalid_d;
  logic        wr_err_q, wr_err_d;

  wb_entry_t   head;
  wb_entry_t   push_entry;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        wr_gnt, rd_gnt, pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign wr_gnt = cache.req & cache.we & ~fifo_full &
                  (state_q != READ_REQ) & (state_q != READ_WAIT);
  assign rd_gnt = cache.req & ~cache.we & fifo_empty & (state_q == IDLE);
  assign pop    = (state_q == DRAIN_REQ) & mem.gnt;

  assign push_entry = '{addr: cache.addr, wdata: cache.wdata, be: cache.be};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_gnt),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    cache_rdata_d  = cache_rdata_q;
    cache_rvalid_d = wr_gnt;
    wr_err_d       = wr_err_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = DRAIN_REQ;
          cmd_d   = drain_cmd(head);
        end else if (rd_gnt) begin
          state_d = READ_REQ;
          cmd_d   = read_cmd(cache.addr);
        end
      end
      DRAIN_REQ: begin
        if (mem.gnt) begin
          state_d = DRAIN_WAIT;
          cmd_d   = '0;
        end
      end
      DRAIN_WAIT: begin
        if (mem.rvalid) begin
          wr_err_d = wr_err_q | mem.error;
          if (!fifo_empty) begin
            state_d = DRAIN_REQ;
            cmd_d   = drain_cmd(head);
          end else begin
            state_d = IDLE;
          end
        end
      end
      READ_REQ: begin
        if (mem.gnt) begin
          state_d = READ_WAIT;
          cmd_d   = '0;
        end
      end
      READ_WAIT: begin
        if (mem.rvalid) begin
          cache_rdata_d  = mem.rdata;
          cache_rvalid_d = 1'b1;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cmd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cmd_q          <= '0;
      cache_rdata_q  <= '0;
      cache_rvalid_q <= 1'b0;
      wr_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      cache_rdata_q  <= cache_rdata_d;
      cache_rvalid_q <= cache_rvalid_d;
      wr_err_q       <= wr_err_d;
    end
  end

  assign cache.gnt    = wr_gnt | rd_gnt;
  assign cache.rdata  = cache_rdata_q;
  assign cache.rvalid = cache_rvalid_q;
  assign cache.error  = 1'b0;

  assign mem.req   = cmd_q.req;
  assign mem.we    = cmd_q.we;
  assign mem.addr  = cmd_q.addr;
  assign mem.wdata = cmd_q.wdata;
  assign mem.be    = cmd_q.be;

  assign wr_err_o = wr_err_q;
  assign empty_o  = fifo_empty & (state_q != DRAIN_REQ) & (state_q != DRAIN_WAIT);

endmodule

// File: tb/tb_mem_write_buffer.sv
// Randomized bench for mem_write_buffer: a scoreboard of issued writes checks
// memory order, a word-level memory model checks read-after-write data.
module tb_mem_write_buffer;
  import mem_wb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_err;
  logic empty;

  always #5 clk = ~clk;

  mem_write_buffer_if cache ();
  mem_write_buffer_if mem ();

  mem_write_buffer #(
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cache    (cache),
    .mem      (mem),
    .wr_err_o (wr_err),
    .empty_o  (empty)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  wb_entry_t   exp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] mem_store[logic [31:0]];
  int          acc_cyc_q[$];
  int          gnt_mode = 0;
  bit          inject_err = 1'b0;
  int          mem_wr_cnt = 0;
  int          last_wr_rsp_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_val(a);
  endfunction

  // Memory responder: grants per gnt_mode, answers each accepted request once.
  initial begin
    bit          rsp_pending = 1'b0;
    int          rsp_wait = 0;
    logic [31:0] rsp_data = '0;
    bit          rsp_err = 1'b0;
    bit          rsp_is_wr = 1'b0;
    wb_entry_t   e;
    mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0; mem.error = 1'b0;
    forever begin
      @(negedge clk);
      mem.rvalid = 1'b0; mem.error = 1'b0; mem.rdata = '0;
      if (reset) begin
        rsp_pending = 1'b0;
        mem.gnt = 1'b0;
        continue;
      end
      if (rsp_pending) begin
        if (rsp_wait > 0) begin
          rsp_wait--;
        end else begin
          mem.rvalid = 1'b1; mem.rdata = rsp_data; mem.error = rsp_err;
          rsp_pending = 1'b0;
          if (rsp_is_wr) last_wr_rsp_cyc = cyc;
        end
      end
      case (gnt_mode)
        0:       mem.gnt = 1'b0;
        1:       mem.gnt = 1'b1;
        default: mem.gnt = 1'($urandom_range(0, 1));
      endcase
      if (mem.req && mem.gnt) begin
        chk("mem_one_outstanding", 32'(rsp_pending), 32'd0);
        rsp_pending = 1'b1;
        rsp_wait = (gnt_mode == 2) ? $urandom_range(0, 2) : 0;
        if (mem.we) begin
          chk("mem_wr_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mem_wr_addr", mem.addr, e.addr);
            chk("mem_wr_data", mem.wdata, e.wdata);
            chk("mem_wr_be", 32'(mem.be), 32'(e.be));
          end
          mem_store[mem.addr] = merge(mem_rd(mem.addr), mem.wdata, mem.be);
          rsp_err = inject_err;
          inject_err = 1'b0;
          rsp_is_wr = 1'b1;
          rsp_data = '0;
          mem_wr_cnt++;
          acc_cyc_q.push_back(cyc);
        end else begin
          chk("mem_rd_be", 32'(mem.be), 32'hF);
          rsp_data = mem_rd(mem.addr);
          rsp_err = 1'b0;
          rsp_is_wr = 1'b0;
        end
      end
    end
  end

  // Called at a falling edge; returns at a falling edge with req dropped.
  task automatic cache_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             input int budget, output int gcyc);
    int waited = 0;
    cache.req = 1'b1; cache.we = 1'b1; cache.addr = a; cache.wdata = d; cache.be = be;
    #1;
    while (!cache.gnt && waited < budget) begin
      @(negedge clk); #1; waited++;
    end
    gcyc = cyc;
    chk("wr_gnt", 32'(cache.gnt), 32'd1);
    if (!cache.gnt) begin
      cache.req = 1'b0;
      return;
    end
    exp_q.push_back('{addr: a, wdata: d, be: be});
    ref_mem[a] = merge(ref_rd(a), d, be);
    $display("wr   addr=%h data=%h be=%h gnt_cyc=%0d", a, d, be, gcyc);
    @(negedge clk);
    chk("wr_ack", 32'(cache.rvalid), 32'd1);
    cache.req = 1'b0;
  endtask

  task automatic cache_read(input logic [31:0] a, input int budget, output int gcyc, output int lat);
    int waited = 0;
    logic [31:0] exp;
    lat = 0;
    cache.req = 1'b1; cache.we = 1'b0; cache.addr = a; cache.wdata = '0; cache.be = 4'hF;
    #1;
    while (!cache.gnt && waited < budget) begin
      @(negedge clk); #1; waited++;
    end
    gcyc = cyc;
    chk("rd_gnt", 32'(cache.gnt), 32'd1);
    if (!cache.gnt) begin
      cache.req = 1'b0;
      return;
    end
    exp = ref_rd(a);
    @(negedge clk);
    cache.req = 1'b0;
    waited = 0;
    while (!cache.rvalid && waited < budget) begin
      @(negedge clk); waited++;
    end
    lat = cyc - gcyc;
    chk("rd_rvalid", 32'(cache.rvalid), 32'd1);
    chk("rd_data", cache.rdata, exp);
    $display("rd   addr=%h data=%h gnt_cyc=%0d latency=%0d", a, cache.rdata, gcyc, lat);
  endtask

  task automatic wait_empty(input int budget);
    int w = 0;
    while (!(empty && exp_q.size() == 0) && w < budget) begin
      @(negedge clk); w++;
    end
    chk("empty", 32'(empty), 32'd1);
    chk("sb_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int g, lat, cnt0, w;
    cache.req = 1'b0; cache.we = 1'b0; cache.addr = '0; cache.wdata = '0; cache.be = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem.req), 32'd0);
    chk("rst_mem_we", 32'(mem.we), 32'd0);
    chk("rst_mem_addr", mem.addr, 32'd0);
    chk("rst_mem_be", 32'(mem.be), 32'd0);
    chk("rst_cache_rvalid", 32'(cache.rvalid), 32'd0);
    chk("rst_cache_rdata", cache.rdata, 32'd0);
    chk("rst_cache_error", 32'(cache.error), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Single write with a zero-wait memory.
    gnt_mode = 1;
    cnt0 = mem_wr_cnt;
    cache_write(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, g);
    chk("busy_not_empty", 32'(empty), 32'd0);
    wait_empty(50);
    chk("single_drained", mem_wr_cnt - cnt0, 32'd1);

    // Fill to full with memory stalled, then release it.
    gnt_mode = 0;
    acc_cyc_q.delete();
    for (int i = 0; i < 4; i++) cache_write(32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF, 0, g);
    cache.req = 1'b1; cache.we = 1'b1; cache.addr = 32'h10; cache.wdata = 32'hC0DE_0004; cache.be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_no_gnt", 32'(cache.gnt), 32'd0);
      @(negedge clk);
    end
    gnt_mode = 1;
    cache_write(32'h10, 32'hC0DE_0004, 4'hF, 20, g);
    chk("full_gnt_after_pop", 32'(acc_cyc_q.size() > 0 && g > acc_cyc_q[0]), 32'd1);
    wait_empty(100);

    // Read immediately after a write to the same address.
    last_wr_rsp_cyc = -1;
    cache_write(32'h20, 32'h1234_5678, 4'hF, 0, g);
    cache_read(32'h20, 50, g, lat);
    chk("raw_order", 32'(last_wr_rsp_cyc >= 0 && g > last_wr_rsp_cyc), 32'd1);
    chk("rd_latency_zero_wait", lat, 32'd3);
    chk("rd_data_value", cache.rdata, 32'h1234_5678);

    // Pointer wrap: ten writes, occupancy kept at or below three.
    gnt_mode = 2;
    for (int i = 0; i < 10; i++) begin
      w = 0;
      while (exp_q.size() >= 3 && w < 200) begin
        @(negedge clk); w++;
      end
      chk("wrap_room", 32'(exp_q.size() < 3), 32'd1);
      cache_write(32'h100 + 32'(i * 4), $urandom, 4'($urandom_range(1, 15)), 300, g);
    end
    wait_empty(300);

    // Error on a drained write is sticky.
    gnt_mode = 1;
    chk("wr_err_clear", 32'(wr_err), 32'd0);
    inject_err = 1'b1;
    cache_write(32'h40, 32'hBAD0_0001, 4'hF, 0, g);
    wait_empty(50);
    chk("wr_err_set", 32'(wr_err), 32'd1);
    cache_write(32'h44, 32'h600D_0002, 4'h3, 0, g);
    wait_empty(50);
    chk("wr_err_sticky", 32'(wr_err), 32'd1);

    // Reset while draining three entries.
    gnt_mode = 0;
    for (int i = 0; i < 3; i++) cache_write(32'h80 + 32'(i * 4), $urandom, 4'hF, 0, g);
    repeat (2) @(negedge clk);
    chk("pre_rst_mem_req", 32'(mem.req), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(mem.req), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_wr_err", 32'(wr_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    ref_mem = mem_store;
    gnt_mode = 1;
    cnt0 = mem_wr_cnt;
    repeat (20) @(negedge clk);
    chk("no_stale_writes", mem_wr_cnt - cnt0, 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);
    cache_write(32'h300, 32'h0BAD_CAFE, 4'hF, 0, g);
    wait_empty(50);

    // Randomized mix of reads and writes over a small address window.
    gnt_mode = 2;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cache_read(32'h200 + 32'($urandom_range(0, 7) * 4), 300, g, lat);
        chk("rd_latency_min", 32'(lat >= 3), 32'd1);
      end else begin
        cache_write(32'h200 + 32'($urandom_range(0, 7) * 4), $urandom,
                    4'($urandom_range(1, 15)), 300, g);
      end
    end
    wait_empty(400);
    chk("final_wr_err", 32'(wr_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
